// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture slice: default code width,
// sequencer state encoding and accumulator sizing.
`timescale 1ns/1ps
package adc_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_SAMPLE    = 2'd2,
        ST_PUSH      = 2'd3
    } state_e;

    // Worst-case sum of 2^avg_log2 codes fits without saturation.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/adc_fifo.sv
// Output FIFO for averaged ADC words: register array with a registered head,
// occupancy level and a sticky overflow flag for dropped pushes.
`timescale 1ns/1ps
module adc_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              ovf_q, ovf_d;
    logic              full, empty, pop_ok, push_ok;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        pop_ok  = pop_i && !empty;
        push_ok = push_i && (!full || pop_ok);

        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;

        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end

        // Incoming word becomes the head when it lands on the next read slot.
        if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        ovf_d = ovf_q || (push_i && !push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_o     = head_q;
    assign valid_o    = !empty;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture sequencer: synchronises adc_clk, samples adc_data on each edge,
// averages 2^AVG_LOG2 codes and queues the result in the output FIFO.
//   state     | meaning
//   IDLE      | capture disabled
//   WAIT_EDGE | waiting for a synchronised adc_clk rising edge
//   SAMPLE    | add the captured code to the accumulator
//   PUSH      | write the averaged word into the FIFO
`timescale 1ns/1ps
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          adc_clk,
    input  logic [DATA_W-1:0]             adc_data,
    input  logic                          enable,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    state_e            state_q;
    logic              sync1_q, sync2_q, hist_q;
    logic [DATA_W-1:0] data_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              push_q;
    logic [DATA_W-1:0] push_data_q;
    logic              edge_det;
    logic [ACC_W-1:0]  acc_sum;

    assign edge_det = sync2_q && !hist_q;
    assign acc_sum  = acc_q + ACC_W'(data_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            data_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            sync1_q <= adc_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            push_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_WAIT_EDGE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT_EDGE: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (edge_det) begin
                        data_q  <= adc_data;
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Dropping enable here discards the partial average.
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= ST_PUSH;
                            push_q      <= 1'b1;
                            push_data_q <= DATA_W'(acc_sum >> AVG_LOG2);
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= ST_WAIT_EDGE;
                        end
                    end
                end
                ST_PUSH: begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= enable ? ST_WAIT_EDGE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    adc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (out_ready),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .level_o     (fifo_level),
        .overflow_o  (overflow)
    );

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: two instances (4-sample and 1-sample
// averaging) share the ADC stimulus; monitors pop expected words on handshake.
`timescale 1ns/1ps
module tb_adc_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       adc_clk;
    logic [7:0] adc_data;
    logic       en2, en0, rdy2, rdy0;
    logic [7:0] od2, od0;
    logic       ov2, ov0, ovf2, ovf0;
    logic [3:0] lvl2, lvl0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp2[$];
    logic [7:0] exp0[$];

    always #5 clk = ~clk;

    adc_capture #(.DATA_W(8), .AVG_LOG2(2), .FIFO_DEPTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_data(adc_data),
        .enable(en2), .out_data(od2), .out_valid(ov2), .out_ready(rdy2),
        .overflow(ovf2), .fifo_level(lvl2)
    );

    adc_capture #(.DATA_W(8), .AVG_LOG2(0), .FIFO_DEPTH(8)) u_dut0 (
        .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_data(adc_data),
        .enable(en0), .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
        .overflow(ovf0), .fifo_level(lvl0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic adc_rise(input logic [7:0] code);
        @(negedge clk);
        adc_data = code;
        adc_clk  = 1'b1;
    endtask

    task automatic adc_edge(input logic [7:0] code);
        adc_rise(code);
        repeat (5) @(negedge clk);
        adc_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic adc_word(input logic [7:0] code);
        repeat (4) adc_edge(code);
    endtask

    initial begin
        forever begin
            @(negedge clk); #1;
            if (!rst && ov2 && rdy2) begin
                if (exp2.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL word2_unexpected: got %0d expected none", od2);
                end else begin
                    chk("word2", od2, exp2.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #1;
            if (!rst && ov0 && rdy0) begin
                if (exp0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL word0_unexpected: got %0d expected none", od0);
                end else begin
                    chk("word0", od0, exp0.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; adc_clk = 1'b0; adc_data = '0;
        en2 = 1'b0; en0 = 1'b0; rdy2 = 1'b1; rdy0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", ov2, 0);
        chk("rst_data", od2, 0);
        chk("rst_ovf", ovf2, 0);
        chk("rst_level", lvl2, 0);
        rst = 1'b0;

        // Four-sample average and edge-to-valid latency.
        en2 = 1'b1;
        repeat (2) @(negedge clk);
        exp2.push_back(8'd25);
        adc_edge(8'd10); adc_edge(8'd20); adc_edge(8'd30);
        adc_rise(8'd41);
        repeat (4) @(negedge clk);
        chk("lat_early", ov2, 0);
        @(negedge clk);
        chk("lat_valid", ov2, 1);
        adc_clk = 1'b0;
        repeat (8) @(negedge clk);
        chk("avg_drained", lvl2, 0);

        // Single-sample mode passes codes straight through.
        en2 = 1'b0; en0 = 1'b1;
        exp0.push_back(8'h00); exp0.push_back(8'hFF); exp0.push_back(8'h80);
        adc_edge(8'h00); adc_edge(8'hFF); adc_edge(8'h80);
        en0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("pass_drained", lvl0, 0);

        // Nine words into a stalled FIFO: the ninth is dropped.
        rdy2 = 1'b0; en2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp2.push_back(8'(k * 10 + 5));
            adc_word(8'(k * 10 + 5));
        end
        chk("fill_level", lvl2, 8);
        chk("fill_ovf", ovf2, 0);
        adc_word(8'd95);
        chk("drop_level", lvl2, 8);
        chk("drop_ovf", ovf2, 1);
        en2 = 1'b0; rdy2 = 1'b1;
        repeat (12) @(negedge clk);
        chk("drop_drained", lvl2, 0);
        chk("ovf_sticky", ovf2, 1);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("ovf_cleared", ovf2, 0);

        // Full FIFO with a pop on the push cycle accepts the word.
        rdy2 = 1'b0; en2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp2.push_back(8'(k * 3));
            adc_word(8'(k * 3));
        end
        chk("full_level", lvl2, 8);
        exp2.push_back(8'd200);
        repeat (3) adc_edge(8'd200);
        adc_rise(8'd200);
        repeat (4) @(negedge clk);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        chk("pushpop_level", lvl2, 8);
        chk("pushpop_ovf", ovf2, 0);
        adc_clk = 1'b0;
        repeat (5) @(negedge clk);
        rdy2 = 1'b1;
        repeat (12) @(negedge clk);
        chk("pushpop_drained", lvl2, 0);
        chk("pushpop_ovf_end", ovf2, 0);

        // Partial average abandoned when enable drops.
        adc_edge(8'd250); adc_edge(8'd250);
        en2 = 1'b0;
        repeat (3) @(negedge clk);
        en2 = 1'b1;
        exp2.push_back(8'd100);
        adc_word(8'd100);
        repeat (5) @(negedge clk);
        chk("abort_drained", lvl2, 0);

        // Reset mid-SAMPLE discards queued words and the partial sum.
        rdy2 = 1'b0;
        adc_word(8'd7); adc_word(8'd8); adc_word(8'd9);
        chk("pre_rst_level", lvl2, 3);
        adc_rise(8'd50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", ov2, 0);
        chk("rst_mid_level", lvl2, 0);
        repeat (2) @(negedge clk);
        adc_clk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0; rdy2 = 1'b1;
        repeat (2) @(negedge clk);
        exp2.push_back(8'd61);
        adc_edge(8'd60); adc_edge(8'd61); adc_edge(8'd62); adc_edge(8'd63);
        repeat (8) @(negedge clk);
        chk("post_rst_drained", lvl2, 0);

        chk("sb2_empty", exp2.size(), 0);
        chk("sb0_empty", exp0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter: DATA_W, 8, ADC code width.
REQ-002 Parameter: AVG_LOG2, 2, log2 of samples averaged per output word; legal range 0..4.
REQ-003 Parameter: FIFO_DEPTH, 8, output FIFO entries; power of two.
REQ-004 Port: clk  input  1  system clock; one clock domain only.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: adc_clk  input  1  ADC conversion clock, asynchronous to clk; period at least 8 clk periods.
REQ-007 Port: adc_data  input  DATA_W  ADC output code, bit 0 = LSB; stable for one full adc_clk period after each adc_clk rising edge.
REQ-008 Port: enable  input  1  capture enable.
REQ-009 Port: out_data  output  DATA_W  averaged code at FIFO head.
REQ-010 Port: out_valid  output  1  FIFO non-empty.
REQ-011 Port: out_ready  input  1  consumer accepts out_data.
REQ-012 Port: overflow  output  1  sticky flag: an averaged word was dropped.
REQ-013 Port: fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 adc_clk SHALL pass through a 2-flop synchronizer plus a history flop; a rising edge is detected when the second-stage flop is 1 and the history flop is 0.
REQ-015 FSM states SHALL be IDLE, WAIT_EDGE, SAMPLE, PUSH.
REQ-016 IDLE -> WAIT_EDGE when enable=1; accumulator and sample counter cleared on entry to WAIT_EDGE.
REQ-017 WAIT_EDGE -> SAMPLE on the cycle after a detected edge; adc_data is registered and added to the accumulator in SAMPLE.
REQ-018 SAMPLE -> PUSH when the sample counter reaches 2^AVG_LOG2, otherwise -> WAIT_EDGE.
REQ-019 Accumulator width SHALL be DATA_W+AVG_LOG2 with no saturation; pushed value = accumulator >> AVG_LOG2, truncated.
REQ-020 PUSH SHALL last one cycle, write into the FIFO, clear the accumulator, then -> WAIT_EDGE if enable=1, else -> IDLE.
REQ-021 enable=0 in WAIT_EDGE or SAMPLE SHALL discard the partial accumulation and -> IDLE next cycle; no partial word is pushed.
REQ-022 Edges detected outside WAIT_EDGE SHALL be ignored.
REQ-023 FIFO pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL be registered and valid in the same cycle out_valid is high.
REQ-024 Push when full with no pop in that cycle: the word is dropped and overflow is set to 1 until reset.
REQ-025 Push when full with a pop in the same cycle: the push is accepted and the level is unchanged.
REQ-026 Push and pop when empty: out_valid=0 in that cycle; the word appears with out_valid=1 the next cycle.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.
REQ-028 Latency from the edge detected in the final SAMPLE to out_valid on an empty FIFO SHALL be 3 clk cycles.

Reset
REQ-029 While rst=1: FSM=IDLE; accumulator, counter, synchronizer and history flops, FIFO pointers = 0.
REQ-030 While rst=1: out_valid=0, out_data=0, overflow=0, fifo_level=0.
REQ-031 Reset during any state SHALL discard FIFO contents and partial accumulation; capture resumes at the first detected edge after rst=0 with enable=1.

Structure
REQ-032 Shared package adc_pkg SHALL hold the DATA_W default, the FSM state enum and the accumulator-width function.
REQ-033 The FIFO SHALL be a sub-module adc_fifo (register array, full/empty, level) instantiated once.

Verification
REQ-034 AVG_LOG2=2; codes 10,20,30,41 on four edges -> one word 25 (101>>2), out_valid 3 cycles after the 4th edge.
REQ-035 AVG_LOG2=0; codes 0x00,0xFF,0x80 -> words 0x00,0xFF,0x80 in order.
REQ-036 out_ready=0; 9 averaged words -> fifo_level=8, overflow=1, and the first 8 words are read back intact.
REQ-037 FIFO full, out_ready=1 on the push cycle -> push accepted, level stays 8, overflow stays 0.
REQ-038 enable dropped after 2 of 4 samples, then re-enabled; codes 100 x4 -> single word 100 with no stale contribution.
REQ-039 rst pulse mid-SAMPLE with 3 words queued -> out_valid=0 and fifo_level=0 immediately; the next full average is correct.
